// File: rtl/pose_telemetry_tx.sv
// Periodic pose telemetry serializer: snapshots X/Y/theta once per period and
// sends an 11-byte frame (A5, X, Y, theta, XOR checksum) over a UART 8N1 line.
module pose_telemetry_tx #(
  parameter int PERIOD_CYCLES = 5000000,
  parameter int BAUD_DIV      = 434
) (
  input  logic        POSE_TX_CLOCK_50,
  input  logic        POSE_TX_Reset_InHigh,
  input  logic        POSE_TX_ENABLE_InHigh,
  input  logic [16:0] POSE_TX_POSX_InBus,
  input  logic [16:0] POSE_TX_POSY_InBus,
  input  logic [16:0] POSE_TX_THETA_InBus,
  output logic        POSE_TX_TXD_Out,
  output logic        POSE_TX_BUSY_OutHigh,
  output logic        POSE_TX_DROP_OutHigh,
  output logic [1:0]  o_dbg_state
);

  localparam int PW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD_CYCLES - 1);
  localparam logic [BW-1:0] BAUD_LAST   = BW'(BAUD_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [PW-1:0] r_period_cnt;
  logic [BW-1:0] r_baud_cnt;
  logic [1:0]    r_state;
  logic [2:0]    r_bit_idx;
  logic [3:0]    r_byte_idx;
  logic [16:0]   r_pos_x;
  logic [16:0]   r_pos_y;
  logic [16:0]   r_pos_th;
  logic          r_txd;
  logic          r_busy;
  logic          r_drop;

  logic          w_tick;
  logic          w_baud_end;
  logic          w_frame_done;
  logic          w_free;
  logic          w_accept;
  logic          w_drop;
  logic [2:0]    w_next_bit;
  logic [23:0]   w_ext_x;
  logic [23:0]   w_ext_y;
  logic [23:0]   w_ext_th;
  logic [7:0]    w_csum;
  logic [7:0]    w_cur_byte;

  assign w_tick       = (r_period_cnt == PERIOD_LAST);
  assign w_baud_end   = (r_baud_cnt == BAUD_LAST);
  // The last stop-bit edge counts as idle so a coincident tick starts the next frame.
  assign w_frame_done = (r_state == S_STOP) && w_baud_end && (r_byte_idx == 4'd10);
  assign w_free       = (r_state == S_IDLE) || w_frame_done;
  assign w_accept     = w_tick && POSE_TX_ENABLE_InHigh && w_free;
  assign w_drop       = w_tick && !w_free;
  assign w_next_bit   = r_bit_idx + 3'd1;

  assign w_ext_x  = {{7{r_pos_x[16]}}, r_pos_x};
  assign w_ext_y  = {{7{r_pos_y[16]}}, r_pos_y};
  assign w_ext_th = {{7{r_pos_th[16]}}, r_pos_th};
  assign w_csum   = w_ext_x[23:16] ^ w_ext_x[15:8] ^ w_ext_x[7:0]
                  ^ w_ext_y[23:16] ^ w_ext_y[15:8] ^ w_ext_y[7:0]
                  ^ w_ext_th[23:16] ^ w_ext_th[15:8] ^ w_ext_th[7:0];

  always_comb begin
    w_cur_byte = 8'hA5;
    case (r_byte_idx)
      4'd1:    w_cur_byte = w_ext_x[23:16];
      4'd2:    w_cur_byte = w_ext_x[15:8];
      4'd3:    w_cur_byte = w_ext_x[7:0];
      4'd4:    w_cur_byte = w_ext_y[23:16];
      4'd5:    w_cur_byte = w_ext_y[15:8];
      4'd6:    w_cur_byte = w_ext_y[7:0];
      4'd7:    w_cur_byte = w_ext_th[23:16];
      4'd8:    w_cur_byte = w_ext_th[15:8];
      4'd9:    w_cur_byte = w_ext_th[7:0];
      4'd10:   w_cur_byte = w_csum;
      default: w_cur_byte = 8'hA5;
    endcase
  end

  always_ff @(posedge POSE_TX_CLOCK_50) begin
    if (POSE_TX_Reset_InHigh) begin
      r_period_cnt <= '0;
      r_baud_cnt   <= '0;
      r_state      <= S_IDLE;
      r_bit_idx    <= 3'd0;
      r_byte_idx   <= 4'd0;
      r_pos_x      <= 17'd0;
      r_pos_y      <= 17'd0;
      r_pos_th     <= 17'd0;
      r_txd        <= 1'b1;
      r_busy       <= 1'b0;
      r_drop       <= 1'b0;
    end else begin
      r_period_cnt <= w_tick ? '0 : r_period_cnt + 1'b1;
      r_drop       <= w_drop;
      if (w_accept) begin
        r_pos_x    <= POSE_TX_POSX_InBus;
        r_pos_y    <= POSE_TX_POSY_InBus;
        r_pos_th   <= POSE_TX_THETA_InBus;
        r_state    <= S_START;
        r_baud_cnt <= '0;
        r_byte_idx <= 4'd0;
        r_bit_idx  <= 3'd0;
        r_txd      <= 1'b0;
        r_busy     <= 1'b1;
      end else if (r_state == S_IDLE) begin
        r_baud_cnt <= '0;
        r_txd      <= 1'b1;
        r_busy     <= 1'b0;
      end else if (!w_baud_end) begin
        r_baud_cnt <= r_baud_cnt + 1'b1;
      end else begin
        // Bit boundary: r_txd is loaded with the level of the bit that starts now.
        r_baud_cnt <= '0;
        case (r_state)
          S_START: begin
            r_state   <= S_DATA;
            r_bit_idx <= 3'd0;
            r_txd     <= w_cur_byte[0];
          end
          S_DATA: begin
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
              r_txd   <= 1'b1;
            end else begin
              r_bit_idx <= w_next_bit;
              r_txd     <= w_cur_byte[w_next_bit];
            end
          end
          S_STOP: begin
            if (r_byte_idx == 4'd10) begin
              r_state    <= S_IDLE;
              r_byte_idx <= 4'd0;
              r_txd      <= 1'b1;
              r_busy     <= 1'b0;
            end else begin
              r_state    <= S_START;
              r_byte_idx <= r_byte_idx + 4'd1;
              r_txd      <= 1'b0;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign POSE_TX_TXD_Out      = r_txd;
  assign POSE_TX_BUSY_OutHigh = r_busy;
  assign POSE_TX_DROP_OutHigh = r_drop;
  assign o_dbg_state          = r_state;

endmodule
